dc_stage: RTL and testbench

- Memory-access stage directly downstream of the execute stage.
- Registers the 76-bit execute-to-DC bus and waits for the data-SRAM load response through a valid handshake.
- Selects the register write-back value and drives the 70-bit DC-to-WB bus.
- Supplies forwarding data to execute and raises a stall request while a load response is still outstanding.

---
 rtl/dc_stage.sv | 142 ++++++++++++++
 tb/tb_dc_stage.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dc_stage.sv
`default_nettype none
// ============================================================================
//  Module      : dc_stage
//  Description : Memory-access (DC) pipeline stage. Registers the execute
//                bus, waits for the data-SRAM load response, selects the
//                write-back value, feeds forwarding data back to execute and
//                requests a stall while a load response is outstanding.
//  Revision    : 1.0 - initial release
// ============================================================================
module dc_stage #(
    parameter int EX_TO_DC_WD = 76,
    parameter int DC_TO_WB_WD = 70
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic [5:0]             stall,
    input  logic [EX_TO_DC_WD-1:0] ex_to_dc_bus,
    input  logic [31:0]            data_sram_rdata,
    input  logic                   data_sram_rvalid,
    output logic [DC_TO_WB_WD-1:0] dc_to_wb_bus,
    output logic                   dc_fwd_we,
    output logic [4:0]             dc_fwd_waddr,
    output logic [31:0]            dc_fwd_wdata,
    output logic                   stallreq_dc
);

    // IDLE: no load, or a load still waiting for its response.
    // GOT : the load response has been captured into the hold buffer.
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_GOT  = 1'b1
    } state_t;

    logic [EX_TO_DC_WD-1:0] r_stage_q;
    logic [EX_TO_DC_WD-1:0] w_stage_d;
    state_t                 r_state_q;
    state_t                 w_state_d;
    logic [31:0]            r_buf_q;
    logic [31:0]            w_buf_d;

    // Decoded fields of the registered execute bus
    logic [31:0] w_pc;
    logic        w_ram_en;
    logic [3:0]  w_ram_wen;
    logic        w_sel_rf_res;
    logic        w_rf_we;
    logic [4:0]  w_rf_waddr;
    logic [31:0] w_alu_result;

    logic        w_is_load;
    logic        w_stage_load;
    logic        w_stage_bubble;
    logic        w_stage_moves;
    logic        w_rsp_now;
    logic [31:0] w_load_data;
    logic [31:0] w_rf_wdata;
    logic        w_rf_we_eff;
    logic        w_stallreq;

    // Only this stage's and the write-back stall bits matter here.
    logic        w_unused_stall;
    assign w_unused_stall = ^stall[3:0];

    assign w_pc         = r_stage_q[75:44];
    assign w_ram_en     = r_stage_q[43];
    assign w_ram_wen    = r_stage_q[42:39];
    assign w_sel_rf_res = r_stage_q[38];
    assign w_rf_we      = r_stage_q[37];
    assign w_rf_waddr   = r_stage_q[36:32];
    assign w_alu_result = r_stage_q[31:0];

    // Decode load status, stage movement and the write-back value
    always_comb begin
        w_is_load      = w_ram_en & (w_ram_wen == 4'b0000);
        w_stage_load   = ~stall[4];
        w_stage_bubble = stall[4] & ~stall[5];
        w_stage_moves  = w_stage_load | w_stage_bubble;
        // A response only counts while still waiting for one; stray pulses
        // in GOT or for non-loads are ignored.
        w_rsp_now      = w_is_load & (r_state_q == ST_IDLE) & data_sram_rvalid;
        w_load_data    = w_rsp_now ? data_sram_rdata : r_buf_q;
        w_stallreq     = w_is_load & (r_state_q == ST_IDLE) & ~data_sram_rvalid;
        w_rf_wdata     = w_sel_rf_res ? w_load_data : w_alu_result;
        w_rf_we_eff    = w_rf_we & ~w_stallreq;
    end

    // Next stage-register contents: flush > bubble > load > hold
    always_comb begin
        w_stage_d = r_stage_q;
        if (flush) begin
            w_stage_d = '0;
        end else if (w_stage_bubble) begin
            w_stage_d = '0;
        end else if (w_stage_load) begin
            w_stage_d = ex_to_dc_bus;
        end
    end

    // Load-response FSM next state and hold-buffer capture
    always_comb begin
        w_state_d = r_state_q;
        w_buf_d   = r_buf_q;
        if (flush) begin
            w_state_d = ST_IDLE;
            w_buf_d   = '0;
        end else begin
            if (w_rsp_now) begin
                w_state_d = ST_GOT;
                w_buf_d   = data_sram_rdata;
            end
            // A new instruction (or bubble) always starts out waiting.
            if (w_stage_moves) begin
                w_state_d = ST_IDLE;
            end
        end
    end

    // Stage register, FSM state and hold buffer
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stage_q <= '0;
            r_state_q <= ST_IDLE;
            r_buf_q   <= '0;
        end else begin
            r_stage_q <= w_stage_d;
            r_state_q <= w_state_d;
            r_buf_q   <= w_buf_d;
        end
    end

    // Output bus and forwarding path
    always_comb begin
        dc_to_wb_bus = {w_pc, w_rf_we_eff, w_rf_waddr, w_rf_wdata};
        dc_fwd_we    = w_rf_we_eff;
        dc_fwd_waddr = w_rf_waddr;
        dc_fwd_wdata = w_rf_wdata;
        stallreq_dc  = w_stallreq;
    end

endmodule
`default_nettype wire

// File: tb/tb_dc_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dc_stage
//  Description : Self-checking bench for dc_stage: directed vectors, a
//                behavioural stage model compared every cycle, and literal
//                expectations at key points.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dc_stage;

    logic        clk;
    logic        rst;
    logic        flush;
    logic [5:0]  stall;
    logic [75:0] ex_to_dc_bus;
    logic [31:0] data_sram_rdata;
    logic        data_sram_rvalid;
    logic [69:0] dc_to_wb_bus;
    logic        dc_fwd_we;
    logic [4:0]  dc_fwd_waddr;
    logic [31:0] dc_fwd_wdata;
    logic        stallreq_dc;

    int n_vec;
    int n_bad;

    dc_stage #(.EX_TO_DC_WD(76), .DC_TO_WB_WD(70)) dut (
        .clk              (clk),
        .rst              (rst),
        .flush            (flush),
        .stall            (stall),
        .ex_to_dc_bus     (ex_to_dc_bus),
        .data_sram_rdata  (data_sram_rdata),
        .data_sram_rvalid (data_sram_rvalid),
        .dc_to_wb_bus     (dc_to_wb_bus),
        .dc_fwd_we        (dc_fwd_we),
        .dc_fwd_waddr     (dc_fwd_waddr),
        .dc_fwd_wdata     (dc_fwd_wdata),
        .stallreq_dc      (stallreq_dc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // The instruction currently held by the stage, and whether its load
    // data has already been received (and what it was).
    logic [31:0] m_pc;
    logic        m_en;
    logic [3:0]  m_wen;
    logic        m_sel;
    logic        m_we;
    logic [4:0]  m_waddr;
    logic [31:0] m_alu;
    logic        m_have;
    logic [31:0] m_data;

    task automatic m_clear_instr();
        m_pc = 0; m_en = 0; m_wen = 0; m_sel = 0; m_we = 0; m_waddr = 0; m_alu = 0;
    endtask

    always @(posedge clk) begin
        logic waiting;
        if (rst || flush) begin
            m_clear_instr();
            m_have = 1'b0;
            m_data = 32'h0;
        end else begin
            waiting = m_en && (m_wen == 4'h0) && !m_have;
            if (waiting && data_sram_rvalid) begin
                m_have = 1'b1;
                m_data = data_sram_rdata;
            end
            if (!(stall[4] && stall[5])) begin
                m_have = 1'b0;
                if (stall[4]) begin
                    m_clear_instr();
                end else begin
                    m_pc    = ex_to_dc_bus[75:44];
                    m_en    = ex_to_dc_bus[43];
                    m_wen   = ex_to_dc_bus[42:39];
                    m_sel   = ex_to_dc_bus[38];
                    m_we    = ex_to_dc_bus[37];
                    m_waddr = ex_to_dc_bus[36:32];
                    m_alu   = ex_to_dc_bus[31:0];
                end
            end
        end
    end

    task automatic chk(input string name, input logic [75:0] act, input logic [75:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare DUT against the model every cycle, mid-cycle
    always @(negedge clk) begin
        logic        waiting;
        logic        pend;
        logic [31:0] word;
        logic [31:0] wd;
        logic        we;
        waiting = m_en && (m_wen == 4'h0) && !m_have;
        pend    = waiting && !data_sram_rvalid;
        word    = (waiting && data_sram_rvalid) ? data_sram_rdata : m_data;
        wd      = m_sel ? word : m_alu;
        we      = m_we && !pend;
        chk("model_bus",      {6'b0, dc_to_wb_bus}, {6'b0, m_pc, we, m_waddr, wd});
        chk("model_fwd_we",   {75'b0, dc_fwd_we},   {75'b0, we});
        chk("model_fwd_addr", {71'b0, dc_fwd_waddr}, {71'b0, m_waddr});
        chk("model_fwd_data", {44'b0, dc_fwd_wdata}, {44'b0, wd});
        chk("model_stallreq", {75'b0, stallreq_dc}, {75'b0, pend});
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [75:0] mk(input logic [31:0] pc, input logic en, input logic [3:0] wen,
                                       input logic sel, input logic we, input logic [4:0] wa,
                                       input logic [31:0] alu);
        return {pc, en, wen, sel, we, wa, alu};
    endfunction

    task automatic drive(input logic [75:0] bus, input logic [5:0] st, input logic fl,
                         input logic rv, input logic [31:0] rd);
        ex_to_dc_bus     = bus;
        stall            = st;
        flush            = fl;
        data_sram_rvalid = rv;
        data_sram_rdata  = rd;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected end of stimulus");
        $fatal(1, "timeout");
    end

    initial begin
        n_vec = 0;
        n_bad = 0;
        rst   = 1'b1;
        drive(76'h0, 6'h0, 1'b0, 1'b0, 32'h0);
        step(); step();
        settle();
        chk("rst_bus",      {6'b0, dc_to_wb_bus}, 76'h0);
        chk("rst_stallreq", {75'b0, stallreq_dc}, 76'h0);
        chk("rst_fwd_we",   {75'b0, dc_fwd_we},   76'h0);
        rst = 1'b0;

        // ALU op
        drive(mk(32'h100, 0, 4'h0, 0, 1, 5'd5, 32'h1234), 6'h0, 0, 0, 0);
        step();
        drive(76'h0, 6'h0, 0, 0, 0);
        settle();
        chk("alu_bus", {6'b0, dc_to_wb_bus}, {6'b0, 32'h100, 1'b1, 5'd5, 32'h0000_1234});
        chk("alu_fwd_data", {44'b0, dc_fwd_wdata}, {44'b0, 32'h0000_1234});
        chk("alu_fwd_addr", {71'b0, dc_fwd_waddr}, {71'b0, 5'd5});
        chk("alu_stallreq", {75'b0, stallreq_dc}, 76'h0);
        step();

        // Load answered in the same cycle
        drive(mk(32'h104, 1, 4'h0, 1, 1, 5'd8, 32'hAAAA), 6'h0, 0, 0, 0);
        step();
        drive(76'h0, 6'h0, 0, 1, 32'hDEAD_BEEF);
        settle();
        chk("ld1_wdata",    {44'b0, dc_fwd_wdata}, {44'b0, 32'hDEAD_BEEF});
        chk("ld1_fwd_we",   {75'b0, dc_fwd_we},   {75'b0, 1'b1});
        chk("ld1_stallreq", {75'b0, stallreq_dc}, 76'h0);
        step();

        // Load answered three cycles after registration, stall held
        drive(mk(32'h108, 1, 4'h0, 1, 1, 5'd9, 32'h5555), 6'h0, 0, 0, 0);
        step();
        for (int i = 0; i < 2; i++) begin
            drive(mk(32'h10C, 0, 4'h0, 0, 1, 5'd3, 32'h77), 6'b111111, 0, 0, 32'h0BAD_0BAD);
            settle();
            chk("ld3_pending_stallreq", {75'b0, stallreq_dc}, {75'b0, 1'b1});
            chk("ld3_pending_fwd_we",   {75'b0, dc_fwd_we},   76'h0);
            step();
        end
        drive(mk(32'h10C, 0, 4'h0, 0, 1, 5'd3, 32'h77), 6'b111111, 0, 1, 32'hCAFE_F00D);
        settle();
        chk("ld3_rsp_stallreq", {75'b0, stallreq_dc}, 76'h0);
        chk("ld3_rsp_bus", {6'b0, dc_to_wb_bus}, {6'b0, 32'h108, 1'b1, 5'd9, 32'hCAFE_F00D});
        step();
        // Still stalled, stray response must not disturb the captured word
        drive(mk(32'h10C, 0, 4'h0, 0, 1, 5'd3, 32'h77), 6'b111111, 0, 1, 32'h1111_2222);
        settle();
        chk("ld3_hold_wdata", {44'b0, dc_fwd_wdata}, {44'b0, 32'hCAFE_F00D});
        chk("ld3_hold_we",    {75'b0, dc_fwd_we},   {75'b0, 1'b1});
        step();
        drive(mk(32'h10C, 0, 4'h0, 0, 1, 5'd3, 32'h77), 6'h0, 0, 0, 0);
        step();
        drive(mk(32'h110, 1, 4'hF, 0, 0, 5'd0, 32'h40), 6'h0, 0, 0, 0);
        settle();
        chk("after_ld_bus", {6'b0, dc_to_wb_bus}, {6'b0, 32'h10C, 1'b1, 5'd3, 32'h77});
        step();

        // Store
        drive(mk(32'h114, 0, 4'h0, 0, 1, 5'd7, 32'h99), 6'b010000, 0, 0, 0);
        settle();
        chk("store_stallreq", {75'b0, stallreq_dc}, 76'h0);
        chk("store_bus", {6'b0, dc_to_wb_bus}, {6'b0, 32'h110, 1'b0, 5'd0, 32'h40});
        step();

        // Bubble then hold
        drive(mk(32'h114, 0, 4'h0, 0, 1, 5'd7, 32'h99), 6'h0, 0, 0, 0);
        settle();
        chk("bubble_bus", {6'b0, dc_to_wb_bus}, 76'h0);
        step();
        drive(mk(32'h118, 0, 4'h0, 0, 1, 5'd2, 32'h55), 6'b110000, 0, 0, 0);
        step();
        settle();
        chk("hold_bus", {6'b0, dc_to_wb_bus}, {6'b0, 32'h114, 1'b1, 5'd7, 32'h99});

        // Flush while a load is pending
        drive(mk(32'h11C, 1, 4'h0, 1, 1, 5'd10, 32'h0), 6'h0, 0, 0, 0);
        step();
        drive(76'h0, 6'b111111, 1, 0, 0);
        settle();
        chk("flush_pre_stallreq", {75'b0, stallreq_dc}, {75'b0, 1'b1});
        step();
        drive(76'h0, 6'b111111, 0, 1, 32'h1234_5678);
        settle();
        chk("flush_stallreq", {75'b0, stallreq_dc}, 76'h0);
        chk("flush_bus",      {6'b0, dc_to_wb_bus}, 76'h0);
        step();
        drive(76'h0, 6'h0, 0, 0, 0);
        settle();
        chk("flush_late_bus", {6'b0, dc_to_wb_bus}, 76'h0);
        chk("flush_late_we",  {75'b0, dc_fwd_we},  76'h0);
        step();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
